// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 6-digit common-anode 7-segment scanner with a blanking gap per slot
module seg_scan_ctrl #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] disp_data,
    input  logic [5:0]  dp_mask,
    input  logic        lz_en,
    input  logic        load,
    input  logic        en,
    output logic [2:0]  bit_disp,
    output logic [7:0]  seg_data,
    output logic        busy
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [6:0] FONT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [23:0]   sh_data;
    logic [5:0]    sh_dp;
    logic          sh_lz;
    logic [3:0]    nib;
    logic          lz_blank;
    logic [6:0]    glyph;

    // a digit is a leading zero when it and every digit above it are zero
    always_comb begin
        nib      = sh_data[{idx, 2'b00} +: 4];
        lz_blank = sh_lz && idx != 3'd0 && (sh_data >> {idx, 2'b00}) == 24'd0;
        glyph    = lz_blank ? 7'h7F : FONT[nib];
    end

    assign busy = state != IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            sh_data  <= '0;
            sh_dp    <= '0;
            sh_lz    <= 1'b0;
            bit_disp <= 3'b111;
            seg_data <= 8'hFF;
        end else begin
            if (load) begin
                sh_data <= disp_data;
                sh_dp   <= dp_mask;
                sh_lz   <= lz_en;
            end
            // select and segments come from the same registered state, so they switch together
            bit_disp <= state == SHOW ? idx : 3'b111;
            seg_data <= state == SHOW ? {~sh_dp[idx], glyph} : 8'hFF;
            if (!en) begin
                state <= IDLE;
                cnt   <= '0;
                idx   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= BLANK;
                        cnt   <= '0;
                        idx   <= '0;
                    end
                    BLANK: begin
                        cnt   <= cnt + 1'b1;
                        state <= cnt == CW'(BLANK_CYCLES - 1) ? SHOW : BLANK;
                    end
                    default: begin
                        if (cnt == CW'(SCAN_DIV - 1)) begin
                            state <= BLANK;
                            cnt   <= '0;
                            idx   <= idx == 3'd5 ? 3'd0 : idx + 3'd1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed checks of reset, scan order, leading-zero/dp, mid-scan load and enable drop
module tb_seg_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] disp_data;
    logic [5:0]  dp_mask;
    logic        lz_en;
    logic        load;
    logic        en;
    logic [2:0]  bit_disp;
    logic [7:0]  seg_data;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    seg_scan_ctrl #(.SCAN_DIV(8), .BLANK_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .disp_data(disp_data), .dp_mask(dp_mask), .lz_en(lz_en),
        .load(load), .en(en), .bit_disp(bit_disp), .seg_data(seg_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int c, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s @%0d: observed %h expected %h", tag, c, obs, exp);
        end
    endtask

    // tbl holds the shown byte for digit d at [d*8 +: 8]; a load of FFFFFF at load_at switches to tbl2
    task automatic scan(input logic [47:0] tbl, input int ncyc, input int load_at, input logic [47:0] tbl2);
        int p, d;
        logic [2:0] eb;
        logic [7:0] es;
        en = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (c == load_at + 1) load = 1'b0;
            p  = (c - 4) % 8;
            d  = ((c - 4) / 8) % 6;
            eb = 3'd7;
            es = 8'hFF;
            if (c >= 4 && p < 6) begin
                eb = 3'(d);
                es = (load_at > 0 && c >= load_at + 2) ? tbl2[d*8 +: 8] : tbl[d*8 +: 8];
            end
            chk("bit_disp", c, {5'd0, bit_disp}, {5'd0, eb});
            chk("seg_data", c, seg_data, es);
            chk("busy", c, {7'd0, busy}, 8'd1);
            if (c == load_at) begin
                load      = 1'b1;
                disp_data = 24'hFFFFFF;
                dp_mask   = 6'd0;
                lz_en     = 1'b0;
            end
        end
    endtask

    task automatic load_word(input logic [23:0] w, input logic [5:0] dp, input logic lz);
        @(negedge clk);
        disp_data = w;
        dp_mask   = dp;
        lz_en     = lz;
        load      = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic stop_scan();
        en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b1;
        load      = 1'b1;
        disp_data = 24'h111111;
        dp_mask   = 6'h3F;
        lz_en     = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk("rst_bit", c, {5'd0, bit_disp}, 8'd7);
            chk("rst_seg", c, seg_data, 8'hFF);
            chk("rst_busy", c, {7'd0, busy}, 8'd0);
        end
        rst  = 1'b0;
        load = 1'b0;
        // shadow must still be zero: digit 0 shows "0" without dp, not "1"
        scan(48'hC0C0C0C0C0C0, 4, 0, 48'd0);
        en = 1'b0;
        @(negedge clk);
        chk("drop_busy", 1, {7'd0, busy}, 8'd0);
        chk("drop_bit", 1, {5'd0, bit_disp}, 8'd0);
        chk("drop_seg", 1, seg_data, 8'hC0);
        @(negedge clk);
        chk("drop_bit", 2, {5'd0, bit_disp}, 8'd7);
        chk("drop_seg", 2, seg_data, 8'hFF);
        load_word(24'h543210, 6'd0, 1'b0);
        scan(48'h9299B0A4F9C0, 90, 77, 48'h8E8E8E8E8E8E);
        stop_scan();
        load_word(24'h000070, 6'b000010, 1'b1);
        scan(48'hFFFFFFFF78C0, 52, 0, 48'd0);
        stop_scan();
        load_word(24'h000000, 6'd0, 1'b1);
        scan(48'hFFFFFFFFFFC0, 52, 0, 48'd0);
        stop_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
